// File: rtl/tc_pl_bus_pkg.sv
// Shared definitions for the PL bus TX chip-select sequencers (write and read side).
package tc_pl_bus_pkg;

    // Default txb word width: one LAST bit plus the select code.
    localparam int AGP0_23_DEF  = 9;
    // Default select code width; always one less than the txb word width.
    localparam int AGP0_25_DEF  = 8;
    // MSB of a txb word carries the LAST flag.
    localparam int LAST_BIT_DEF = AGP0_23_DEF - 1;

    // Sequencer states, encoded identically on both sides of the FIFO.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } csn_state_e;

    // True when any mask bit strictly above position idx is still set.
    function automatic logic any_above(input logic [63:0] mask, input logic [5:0] idx);
        return ((mask >> idx) >> 1'b1) != 64'd0;
    endfunction

endpackage

// File: rtl/tc_pl_bus_tx_csn_wr.sv
// Write-side chip-select sequencer: turns a channel mask into an ordered list of
// select words (lowest channel first) pushed into the txb FIFO, the final word
// tagged with LAST so the read side knows where its pass ends.
module tc_pl_bus_tx_csn_wr
    import tc_pl_bus_pkg::*;
#(
    parameter int AGP0_23 = AGP0_23_DEF,
    parameter int AGP0_25 = AGP0_25_DEF,
    parameter int NCH     = 16,
    parameter int CW      = $clog2(NCH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csn_start,
    input  logic [NCH-1:0]     csn_mask,
    output logic               csn_busy,
    output logic               csn_done,
    output logic [CW-1:0]      csn_wcnt,
    output logic               txb_wen,
    output logic [AGP0_23-1:0] txb_wdata,
    input  logic               txb_full
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    csn_state_e     state_r, state_nx_s;
    logic [NCH-1:0] mask_r, mask_nx_s;
    logic [IW-1:0]  idx_r, idx_nx_s;
    logic [CW-1:0]  wcnt_r, wcnt_nx_s;

    logic               last_s;
    logic [AGP0_25-1:0] sel_s;
    logic               wen_s;
    logic [AGP0_23-1:0] wdata_s;
    logic               done_s;

    // Channel index zero-extended into the select code field.
    assign sel_s  = AGP0_25'(idx_r);
    // Current word is the last one when nothing above it remains to be written.
    assign last_s = ~any_above(64'(mask_r), 6'(idx_r));

    // Next-state and write-port decode; written bits are cleared from mask_r so an
    // all-zero remainder means the list is complete.
    always_comb begin
        state_nx_s = state_r;
        mask_nx_s  = mask_r;
        idx_nx_s   = idx_r;
        wcnt_nx_s  = wcnt_r;
        wen_s      = 1'b0;
        wdata_s    = {AGP0_23{1'b0}};
        done_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (csn_start) begin
                    mask_nx_s  = csn_mask;
                    idx_nx_s   = {IW{1'b0}};
                    wcnt_nx_s  = {CW{1'b0}};
                    state_nx_s = S_SCAN;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_SCAN: begin
                if (mask_r == {NCH{1'b0}}) begin
                    state_nx_s = S_DONE;
                end else if (!mask_r[idx_r]) begin
                    // Remaining set bits are always at or above idx, so this never
                    // runs past NCH-1; the guard just keeps idx from wrapping.
                    if (idx_r != IW'(NCH - 1)) begin
                        idx_nx_s = idx_r + IW'(1);
                    end else begin
                        idx_nx_s = idx_r;
                    end
                end else if (txb_full) begin
                    // Stall: hold index and mask until the FIFO has room.
                    idx_nx_s = idx_r;
                end else begin
                    wen_s            = 1'b1;
                    wdata_s          = {last_s, sel_s};
                    mask_nx_s[idx_r] = 1'b0;
                    wcnt_nx_s        = wcnt_r + CW'(1);
                    if (last_s) begin
                        state_nx_s = S_DONE;
                    end else begin
                        idx_nx_s = idx_r + IW'(1);
                    end
                end
            end
            S_DONE: begin
                done_s     = 1'b1;
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State, captured mask, scan index and word count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            mask_r  <= {NCH{1'b0}};
            idx_r   <= {IW{1'b0}};
            wcnt_r  <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            mask_r  <= mask_nx_s;
            idx_r   <= idx_nx_s;
            wcnt_r  <= wcnt_nx_s;
        end
    end

    assign csn_busy  = (state_r != S_IDLE);
    assign csn_done  = done_s;
    assign csn_wcnt  = wcnt_r;
    assign txb_wen   = wen_s;
    assign txb_wdata = wdata_s;

endmodule

// File: tb/tb_tc_pl_bus_tx_csn_wr.sv
// Directed bench for the write-side chip-select sequencer with a scoreboard of
// expected FIFO words (data and write cycle).
module tb_tc_pl_bus_tx_csn_wr;

    localparam int NCH = 16;
    localparam int CW  = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           csn_start = 1'b0;
    logic [NCH-1:0] csn_mask = 16'h0000;
    logic           csn_busy;
    logic           csn_done;
    logic [CW-1:0]  csn_wcnt;
    logic           txb_wen;
    logic [8:0]     txb_wdata;
    logic           txb_full = 1'b0;

    typedef struct {
        logic [8:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t0 = 0;

    tc_pl_bus_tx_csn_wr dut (
        .clk       (clk),
        .rst       (rst),
        .csn_start (csn_start),
        .csn_mask  (csn_mask),
        .csn_busy  (csn_busy),
        .csn_done  (csn_done),
        .csn_wcnt  (csn_wcnt),
        .txb_wen   (txb_wen),
        .txb_wdata (txb_wdata),
        .txb_full  (txb_full)
    );

    always #5 clk = ~clk;

    // Cycle counter: value k is current during the k-th clock cycle.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the oldest expected word,
    // and the data bus must be zero when no write is strobed.
    always @(negedge clk) begin
        if (txb_wen === 1'b1) begin
            vectors++;
            assert (q.size() > 0) else begin
                miscompares++;
                $error("FAIL extra_write: got %0h expected no write", txb_wdata);
            end
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("wdata", 32'(txb_wdata), 32'(e.data));
                chk("wcycle", 32'(cyc - t0), 32'(e.cyc - t0));
            end
        end else begin
            chk("wdata_idle", 32'(txb_wdata), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a start in cycle T; returns at the beginning of cycle T+1.
    task automatic start_pass(input logic [NCH-1:0] m);
        csn_start = 1'b1;
        csn_mask  = m;
        t0        = cyc;
        step();
        csn_start = 1'b0;
    endtask

    // Expected words for a pass with no FIFO stalls: bit i written at T+1+i.
    task automatic push_pass(input logic [NCH-1:0] m);
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) begin
                exp_t e;
                logic lst;
                lst = 1'b1;
                for (int j = i + 1; j < NCH; j++) begin
                    if (m[j]) lst = 1'b0;
                end
                e.data = {lst, 8'(i)};
                e.cyc  = t0 + 1 + i;
                q.push_back(e);
            end
        end
    endtask

    // Wait (bounded) for csn_done, then check timing, count and return to idle.
    task automatic wait_done(input string tag, input int exp_off, input int exp_cnt);
        int k;
        k = 0;
        while (csn_done !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        chk({tag, "_done_cyc"}, 32'(cyc - t0), 32'(exp_off));
        chk({tag, "_wcnt"}, 32'(csn_wcnt), 32'(exp_cnt));
        chk({tag, "_busy_done"}, 32'(csn_busy), 32'd1);
        step();
        chk({tag, "_busy_idle"}, 32'(csn_busy), 32'd0);
        chk({tag, "_done_low"}, 32'(csn_done), 32'd0);
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        // Reset state
        step();
        step();
        chk("rst_busy", 32'(csn_busy), 32'd0);
        chk("rst_done", 32'(csn_done), 32'd0);
        chk("rst_wcnt", 32'(csn_wcnt), 32'd0);
        chk("rst_wen", 32'(txb_wen), 32'd0);
        rst = 1'b0;
        step();

        // Two sparse bits: 0x000 at T+1, 0x102 at T+3, done at T+4
        start_pass(16'h0005);
        push_pass(16'h0005);
        chk("m5_busy", 32'(csn_busy), 32'd1);
        wait_done("m5", 4, 2);

        // Empty mask: no writes, done at T+2
        start_pass(16'h0000);
        wait_done("m0", 2, 0);

        // FIFO full during T+1..T+3: 0x000 at T+4, 0x10F at T+19
        txb_full = 1'b1;
        start_pass(16'h8001);
        e.data = 9'h000; e.cyc = t0 + 4;  q.push_back(e);
        e.data = 9'h10F; e.cyc = t0 + 19; q.push_back(e);
        step();
        step();
        chk("stall_wen", 32'(txb_wen), 32'd0);
        step();
        txb_full = 1'b0;
        wait_done("stall", 20, 2);

        // All channels: 16 back-to-back writes, done at T+17
        start_pass(16'hFFFF);
        push_pass(16'hFFFF);
        wait_done("mff", 17, 16);

        // Reset during a pass after two words
        start_pass(16'h00FF);
        e.data = 9'h000; e.cyc = t0 + 1; q.push_back(e);
        e.data = 9'h001; e.cyc = t0 + 2; q.push_back(e);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", 32'(csn_busy), 32'd0);
        chk("mrst_done", 32'(csn_done), 32'd0);
        chk("mrst_wcnt", 32'(csn_wcnt), 32'd0);
        chk("mrst_wen", 32'(txb_wen), 32'd0);
        chk("mrst_wdata", 32'(txb_wdata), 32'd0);
        chk("mrst_drained", 32'(q.size()), 32'd0);
        step();
        start_pass(16'h0001);
        push_pass(16'h0001);
        wait_done("post_rst", 2, 1);

        // Start pulse while busy and mask change after capture are ignored
        start_pass(16'h0005);
        push_pass(16'h0005);
        csn_start = 1'b1;
        csn_mask  = 16'hFFFF;
        step();
        csn_start = 1'b0;
        wait_done("ign", 4, 2);
        csn_mask = 16'h0000;
        step();
        step();
        chk("ign_idle", 32'(csn_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
